// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: turns an 8-bit angle into a fixed-period frame
// whose high pulse is MIN_US + angle*US_PER_DEG microseconds long.
module servo_pwm_gen #(
    parameter int CLK_DIV    = 50,
    parameter int FRAME_US   = 20000,
    parameter int MIN_US     = 600,
    parameter int US_PER_DEG = 10,
    parameter int MAX_ANGLE  = 180
) (
    input  logic       Clk,
    input  logic       iRst_n,
    input  logic [7:0] iAngle,
    input  logic       iEn,
    output logic       oPwm,
    output logic       oFrame,
    output logic [7:0] oAngleQ,
    output logic       oClamped
);

    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int US_W = $clog2(FRAME_US);

    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(CLK_DIV - 1);
    localparam logic [US_W-1:0] US_LAST   = US_W'(FRAME_US - 1);
    localparam logic [7:0]      ANGLE_MAX = 8'(MAX_ANGLE);
    localparam logic [US_W-1:0] MIN_LEN   = US_W'(MIN_US);
    localparam logic [US_W-1:0] DEG_LEN   = US_W'(US_PER_DEG);

    logic [PS_W-1:0] prescaler;
    logic [US_W-1:0] us_cnt;
    logic [US_W-1:0] pulse_len;
    logic            en_q;

    logic            tick;
    logic            boundary;
    logic            over;
    logic [7:0]      angle_sat;
    logic [US_W-1:0] pulse_next;

    // The longest legal pulse is below FRAME_US, so US_W bits hold the full
    // product and sum without losing any bits.
    always_comb begin
        tick       = (prescaler == PS_LAST);
        boundary   = tick && (us_cnt == US_LAST);
        over       = (iAngle > ANGLE_MAX);
        angle_sat  = over ? ANGLE_MAX : iAngle;
        pulse_next = MIN_LEN + (US_W'(angle_sat) * DEG_LEN);
    end

    always_ff @(posedge Clk or negedge iRst_n) begin
        if (!iRst_n) begin
            prescaler <= '0;
            us_cnt    <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
            end
        end
    end

    // Angle and enable are captured only at the frame boundary so a pulse in
    // flight is never shortened or stretched by input changes.
    always_ff @(posedge Clk or negedge iRst_n) begin
        if (!iRst_n) begin
            pulse_len <= MIN_LEN;
            en_q      <= 1'b0;
            oFrame    <= 1'b0;
            oAngleQ   <= '0;
            oClamped  <= 1'b0;
        end else begin
            oFrame <= boundary;
            if (boundary) begin
                pulse_len <= pulse_next;
                en_q      <= iEn;
                oAngleQ   <= angle_sat;
                oClamped  <= over;
            end
        end
    end

    always_ff @(posedge Clk or negedge iRst_n) begin
        if (!iRst_n) begin
            oPwm <= 1'b0;
        end else begin
            oPwm <= en_q && (us_cnt < pulse_len);
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with CLK_DIV=2, FRAME_US=3000
// (one frame = 6000 clocks, 1 degree = 20 clocks of pulse).
module tb_servo_pwm_gen;

    logic       clk;
    logic       rst_n;
    logic [7:0] angle;
    logic       en;
    logic       pwm;
    logic       frame;
    logic [7:0] angle_q;
    logic       clamped;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    // Per measured frame: expected pulse, input change applied during it, and
    // the angle/clamp expected to be latched at the boundary that ends it.
    int          exp_high [9] = '{3000, 1200, 4800, 4800, 2100, 1800, 4200, 3000, 0};
    int          chg_at   [9] = '{10,   10,   10,   5999, 10,   500,  10,   100,  3000};
    logic [7:0]  chg_ang  [9] = '{0,    180,  250,  45,   30,   150,  90,   90,   90};
    logic        chg_en   [9] = '{1,    1,    1,    1,    1,    1,    1,    0,    1};
    logic [7:0]  nxt_ang  [9] = '{0,    180,  180,  45,   30,   150,  90,   90,   90};
    logic        nxt_clmp [9] = '{0,    0,    1,    0,    0,    0,    0,    0,    0};

    servo_pwm_gen #(
        .CLK_DIV    (2),
        .FRAME_US   (3000),
        .MIN_US     (600),
        .US_PER_DEG (10),
        .MAX_ANGLE  (180)
    ) dut (
        .Clk      (clk),
        .iRst_n   (rst_n),
        .iAngle   (angle),
        .iEn      (en),
        .oPwm     (pwm),
        .oFrame   (frame),
        .oAngleQ  (angle_q),
        .oClamped (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts clocks (and pwm-high clocks) until the next frame strobe.
    task automatic wait_frame(output int cycles, output int highs);
        cycles = 0;
        highs  = 0;
        for (int n = 1; n <= 7000; n++) begin
            @(negedge clk);
            if (pwm) highs++;
            if (frame) begin
                cycles = n;
                break;
            end
        end
    endtask

    // Starts just after a strobe; runs to the next strobe, applying one input
    // change at clock chg_n of the frame.
    task automatic measure_frame(input int chg_n, input logic [7:0] new_ang, input logic new_en,
                                 output int len, output int highs, output int rise);
        len   = 0;
        highs = 0;
        rise  = -1;
        for (int n = 1; n <= 7000; n++) begin
            @(negedge clk);
            if (pwm) begin
                highs++;
                if (rise < 0) rise = n;
            end
            if (frame) begin
                len = n;
                break;
            end
            if (n == chg_n) begin
                angle = new_ang;
                en    = new_en;
            end
        end
    endtask

    initial begin
        int cyc, hi, len, rise;
        logic [31:0] exp_h;

        rst_n = 1'b0;
        angle = 8'd90;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pwm", {31'd0, pwm}, 0);
        check("reset_frame", {31'd0, frame}, 0);
        check("reset_angle_q", {24'd0, angle_q}, 0);
        check("reset_clamped", {31'd0, clamped}, 0);

        rst_n = 1'b1;
        wait_frame(cyc, hi);
        check("first_frame_delay", cyc, 6000);
        check("no_pulse_before_first_frame", hi, 0);
        check("f0_angle_q", {24'd0, angle_q}, 90);
        check("f0_clamped", {31'd0, clamped}, 0);

        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(32'(exp_high[i]));
            measure_frame(chg_at[i], chg_ang[i], chg_en[i], len, hi, rise);
            exp_h = exp_q.pop_front();
            check($sformatf("f%0d_period", i + 1), len, 6000);
            check($sformatf("f%0d_high", i + 1), hi, exp_h);
            if (exp_h != 0) check($sformatf("f%0d_rise", i + 1), rise, 1);
            check($sformatf("f%0d_next_angle_q", i + 1), {24'd0, angle_q}, {24'd0, nxt_ang[i]});
            check($sformatf("f%0d_next_clamped", i + 1), {31'd0, clamped}, {31'd0, nxt_clmp[i]});
        end

        // Re-enabled frame is pulsing; hit reset in the middle of the pulse.
        repeat (100) @(negedge clk);
        check("resume_pulse_high", {31'd0, pwm}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pwm", {31'd0, pwm}, 0);
        check("async_reset_frame", {31'd0, frame}, 0);
        check("async_reset_angle_q", {24'd0, angle_q}, 0);
        check("async_reset_clamped", {31'd0, clamped}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame(cyc, hi);
        check("post_reset_frame_delay", cyc, 6000);
        check("post_reset_no_pulse", hi, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
